// File: rtl/pipe_stage_if.sv
// Handshake and sideband bundle for pipe_stage_reg: upstream (in_*), downstream (out_*), flush and status.
// The master modport is the side that drives the stage; the slave modport is the stage itself.
interface pipe_stage_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = 32,
    parameter int unsigned CW    = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_exc;
    logic [AW-1:0]    in_exc_addr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_exc;
    logic [AW-1:0]    out_exc_addr;
    logic [1:0]       occupancy;
    logic [CW-1:0]    stall_cycles;

    modport master (
        output in_valid, in_data, in_exc, in_exc_addr, flush, out_ready,
        input  in_ready, out_valid, out_data, out_exc, out_exc_addr, occupancy, stall_cycles
    );

    modport slave (
        input  in_valid, in_data, in_exc, in_exc_addr, flush, out_ready,
        output in_ready, out_valid, out_data, out_exc, out_exc_addr, occupancy, stall_cycles
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// One-cycle pipeline stage register with flush, exception sideband and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned AW             = 32,
    parameter int unsigned CW             = 16,
    parameter bit          ZERO_ON_BUBBLE = 1'b1
) (
    input logic         clock,
    input logic         reset_n,
    pipe_stage_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             exc;
        logic [AW-1:0]    exc_addr;
    } entry_t;

    localparam logic [CW-1:0] STALL_MAX = {CW{1'b1}};

    entry_t        in_entry_c;
    entry_t        head_q;
    entry_t        head_d;
    logic [1:0]    occ_q;
    logic [1:0]    occ_d;
    logic [CW-1:0] stall_q;
    logic [CW-1:0] stall_d;
    logic          in_ready_c;
    logic          in_xfer_c;
    logic          out_xfer_c;

    assign in_entry_c = '{data: bus.in_data, exc: bus.in_exc, exc_addr: bus.in_exc_addr};
    assign out_xfer_c = (occ_q != 2'd0) && bus.out_ready;
    assign in_xfer_c  = bus.in_valid && in_ready_c && !bus.flush;

`ifdef PIPE_STAGE_SKID_EN
    entry_t skid_q;
    entry_t skid_d;
    logic   in_ready_q;

    // in_ready comes straight from a flop so out_ready never reaches upstream combinationally
    assign in_ready_c = in_ready_q;

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;
        if (bus.flush) begin
            occ_d = 2'd0;
            if (ZERO_ON_BUBBLE) begin
                head_d = '0;
                skid_d = '0;
            end
        end else begin
            case ({in_xfer_c, out_xfer_c})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_d = in_entry_c;
                        occ_d  = 2'd1;
                    end else begin
                        skid_d = in_entry_c;
                        occ_d  = 2'd2;
                    end
                end
                2'b01: begin
                    if (occ_q == 2'd2) begin
                        head_d = skid_q;
                        occ_d  = 2'd1;
                        if (ZERO_ON_BUBBLE) skid_d = '0;
                    end else begin
                        occ_d = 2'd0;
                        if (ZERO_ON_BUBBLE) head_d = '0;
                    end
                end
                // simultaneous transfers only happen at occupancy 1: the new entry replaces the head
                2'b11: head_d = in_entry_c;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            in_ready_q <= (occ_d != 2'd2);
        end
    end
`else
    assign in_ready_c = (occ_q == 2'd0) || bus.out_ready;

    always_comb begin
        head_d = head_q;
        occ_d  = occ_q;
        if (bus.flush) begin
            occ_d = 2'd0;
            if (ZERO_ON_BUBBLE) head_d = '0;
        end else if (in_xfer_c) begin
            head_d = in_entry_c;
            occ_d  = 2'd1;
        end else if (out_xfer_c) begin
            occ_d = 2'd0;
            if (ZERO_ON_BUBBLE) head_d = '0;
        end
    end
`endif

    // Stall counter: counts held-but-not-taken cycles, saturates, survives flush
    always_comb begin
        stall_d = stall_q;
        if ((occ_q != 2'd0) && !bus.out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            occ_q   <= 2'd0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            occ_q   <= occ_d;
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = (occ_q != 2'd0);
    assign bus.out_data     = head_q.data;
    assign bus.out_exc      = head_q.exc;
    assign bus.out_exc_addr = head_q.exc_addr;
    assign bus.occupancy    = occ_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table plus ordering, scoreboard, stall and reset sequences.
module tb_pipe_stage_reg;
    logic clock;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    pipe_stage_if #(.WIDTH(64), .AW(32), .CW(4)) bus ();

    pipe_stage_reg #(.WIDTH(64), .AW(32), .CW(4), .ZERO_ON_BUBBLE(1'b1)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [63:0] d;
        logic        e;
        logic [31:0] a;
        logic        fl;
        logic        orr;
        logic        ev;
        logic [63:0] ed;
        logic        ee;
        logic [31:0] ea;
        logic [1:0]  eocc;
        logic [3:0]  estall;
    } vec_t;

    vec_t vecs[9];

    logic [63:0] qd[$];
    logic        qe[$];
    logic [31:0] qa[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [63:0] d, input logic e,
                         input logic [31:0] a, input logic fl, input logic orr);
        bus.in_valid    = iv;
        bus.in_data     = d;
        bus.in_exc      = e;
        bus.in_exc_addr = a;
        bus.flush       = fl;
        bus.out_ready   = orr;
    endtask

    task automatic step(input logic iv, input logic [63:0] d, input logic fl, input logic orr);
        @(negedge clock);
        drive(iv, d, 1'b0, 32'h0, fl, orr);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int sent;
        int recv;
        vecs[0] = '{1'b1, 64'h1234, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 64'h1234, 1'b0, 32'h0,        2'd1, 4'd0};
        vecs[1] = '{1'b1, 64'hA1,   1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 64'hA1,   1'b1, 32'hDEADBEEF, 2'd1, 4'd0};
        vecs[2] = '{1'b0, 64'h0,    1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 64'hA1,   1'b1, 32'hDEADBEEF, 2'd1, 4'd1};
        vecs[3] = '{1'b0, 64'h0,    1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 32'h0,        2'd0, 4'd1};
        vecs[4] = '{1'b1, 64'h55,   1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 64'h55,   1'b0, 32'h0,        2'd1, 4'd1};
        vecs[5] = '{1'b1, 64'h66,   1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 32'h0,        2'd0, 4'd2};
        vecs[6] = '{1'b0, 64'h0,    1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 32'h0,        2'd0, 4'd2};
        vecs[7] = '{1'b1, 64'h77,   1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 64'h77,   1'b0, 32'h0,        2'd1, 4'd2};
        vecs[8] = '{1'b0, 64'h0,    1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 32'h0,        2'd0, 4'd3};

        reset_n = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst out_data", bus.out_data, 64'd0);
        chk("rst occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst stall", 64'(bus.stall_cycles), 64'd0);
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);

        // Table: reset released on the same negedge the first vector is driven
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (i == 0) reset_n = 1'b1;
            drive(vecs[i].iv, vecs[i].d, vecs[i].e, vecs[i].a, vecs[i].fl, vecs[i].orr);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].ed);
            chk($sformatf("vec%0d out_exc", i), 64'(bus.out_exc), 64'(vecs[i].ee));
            chk($sformatf("vec%0d out_exc_addr", i), 64'(bus.out_exc_addr), 64'(vecs[i].ea));
            chk($sformatf("vec%0d occupancy", i), 64'(bus.occupancy), 64'(vecs[i].eocc));
            chk($sformatf("vec%0d stall", i), 64'(bus.stall_cycles), 64'(vecs[i].estall));
        end

        // Ordering under backpressure
        step(1'b1, 64'hAAAA, 1'b0, 1'b0);
        chk("ord A head", bus.out_data, 64'hAAAA);
        chk("ord A occ", 64'(bus.occupancy), 64'd1);
        step(1'b1, 64'hBBBB, 1'b0, 1'b0);
        chk("ord B occ", 64'(bus.occupancy), SKID ? 64'd2 : 64'd1);
        chk("ord B in_ready", 64'(bus.in_ready), 64'd0);
        chk("ord B head", bus.out_data, 64'hAAAA);
        step(!SKID, 64'hBBBB, 1'b0, 1'b1);
        chk("ord drain head", bus.out_data, 64'hBBBB);
        chk("ord drain occ", 64'(bus.occupancy), 64'd1);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        chk("ord empty valid", 64'(bus.out_valid), 64'd0);
        chk("ord empty data", bus.out_data, 64'd0);

        // Scoreboard under random out_ready
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 200 && recv < 5; cyc++) begin
            @(negedge clock);
            bus.flush       = 1'b0;
            bus.out_ready   = 1'($urandom_range(0, 1));
            bus.in_valid    = (sent < 5);
            bus.in_data     = 64'h1000 + 64'(sent);
            bus.in_exc      = (sent == 2);
            bus.in_exc_addr = (sent == 2) ? 32'hDEADBEEF : 32'(sent);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (qd.size() == 0) begin
                    chk("sb unexpected output", 64'd1, 64'd0);
                end else begin
                    chk($sformatf("sb%0d data", recv), bus.out_data, qd[0]);
                    chk($sformatf("sb%0d exc", recv), 64'(bus.out_exc), 64'(qe[0]));
                    chk($sformatf("sb%0d exc_addr", recv), 64'(bus.out_exc_addr), 64'(qa[0]));
                    void'(qd.pop_front());
                    void'(qe.pop_front());
                    void'(qa.pop_front());
                end
                recv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                qd.push_back(bus.in_data);
                qe.push_back(bus.in_exc);
                qa.push_back(bus.in_exc_addr);
                sent++;
            end
            @(posedge clock);
        end
        chk("sb drained count", 64'(recv), 64'd5);

        // Stall saturation, flush persistence and async reset clear
        @(negedge clock);
        drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("stall rst0 clear", 64'(bus.stall_cycles), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 64'h9, 1'b0, 1'b0);
        chk("stall first accept", 64'(bus.occupancy), 64'd1);
        chk("stall start", 64'(bus.stall_cycles), 64'd0);
        @(negedge clock);
        drive(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (20) @(posedge clock);
        #1;
        chk("stall saturated", 64'(bus.stall_cycles), 64'd15);
        repeat (3) @(posedge clock);
        #1;
        chk("stall holds", 64'(bus.stall_cycles), 64'd15);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("stall flush occ", 64'(bus.occupancy), 64'd0);
        chk("stall after flush", 64'(bus.stall_cycles), 64'd15);
        step(1'b1, 64'h42, 1'b0, 1'b0);
        chk("midop load", bus.out_data, 64'h42);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst stall", 64'(bus.stall_cycles), 64'd0);
        chk("async rst occ", 64'(bus.occupancy), 64'd0);
        chk("async rst valid", 64'(bus.out_valid), 64'd0);
        chk("async rst data", bus.out_data, 64'd0);
        chk("async rst in_ready", 64'(bus.in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be named clock and reset_n.
REQ-002 Parameter WIDTH, default 64, SHALL set the payload width in bits (minimum 1).
REQ-003 Parameter AW, default 32, SHALL set the faulty-address sideband width.
REQ-004 Parameter CW, default 16, SHALL set the stall-counter width.
REQ-005 Parameter ZERO_ON_BUBBLE, default 1, SHALL set whether empty entries hold all-zero data.
REQ-006 Ports SHALL be as follows:
- clock  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage accepts an entry
- in_data  in  WIDTH  payload (controls, operands, pc)
- in_exc  in  1  upstream exception flag
- in_exc_addr  in  AW  upstream faulty address
- flush  in  1  insert bubble by discarding all held entries
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  head payload
- out_exc  out  1  head exception flag
- out_exc_addr  out  AW  head faulty address
- occupancy  out  2  number of held entries
- stall_cycles  out  CW  backpressure cycle counter

Function
REQ-007 An input transfer SHALL occur on a rising edge with in_valid=1, in_ready=1 and flush=0; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-008 The stage SHALL deliver entries in order, with data, exc and exc_addr kept together, and with no loss or duplication.
REQ-009 Latency SHALL be one cycle: an entry accepted into an empty stage SHALL appear on out_* in the next cycle.
REQ-010 out_valid SHALL equal (occupancy != 0), and the out_* fields SHALL come from the head entry.
REQ-011 When flush=1 on an edge, occupancy SHALL become 0 and any simultaneous input SHALL be dropped; flush SHALL take priority over every other event.
REQ-012 When ZERO_ON_BUBBLE=1, the data, exc and exc_addr fields of every empty entry SHALL be 0, so out_* are 0 whenever out_valid=0.
REQ-013 When ZERO_ON_BUBBLE=0, empty entries SHALL retain their stale values.
REQ-014 An input transfer and an output transfer on the same edge SHALL leave occupancy unchanged, with the new entry becoming the head on the next cycle.
REQ-015 stall_cycles SHALL increment on each edge where out_valid=1 and out_ready=0.
REQ-016 stall_cycles SHALL saturate at 2^CW-1 and SHALL NOT be cleared by flush.
REQ-017 in_valid and in_data SHALL be ignored while in_ready=0.

Reset
REQ-018 While reset_n=0, all entries, occupancy and stall_cycles SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-019 During and after reset: out_valid=0, out_data=0, out_exc=0, out_exc_addr=0, occupancy=0, stall_cycles=0 and in_ready=1.
REQ-020 Any entry held when reset asserts mid-operation SHALL be discarded.
REQ-021 The first input transfer SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-022 The macro PIPE_STAGE_SKID_EN SHALL select the buffer structure.
REQ-023 When PIPE_STAGE_SKID_EN is defined, the stage SHALL have two entries (main and skid) and occupancy SHALL range 0..2.
REQ-024 With PIPE_STAGE_SKID_EN defined, in_ready SHALL be driven directly from a flop, equal to (occupancy < 2), with no combinational path from out_ready.
REQ-025 With PIPE_STAGE_SKID_EN defined, an input transfer at occupancy 1 with out_ready=0 SHALL fill the skid entry.
REQ-026 With PIPE_STAGE_SKID_EN defined, an output transfer at occupancy 2 SHALL move the skid entry to the head.
REQ-027 When PIPE_STAGE_SKID_EN is undefined, the stage SHALL have one entry, occupancy SHALL range 0..1, and in_ready SHALL equal (!out_valid || out_ready) combinationally.

Verification
REQ-028 Reset, then in_valid=1, in_data=0x1234 with out_ready=1 -> out_valid=1 and out_data=0x1234 exactly one cycle later; occupancy=1.
REQ-029 With PIPE_STAGE_SKID_EN defined, hold out_ready=0 and send A then B -> occupancy=2 and in_ready=0 on the next cycle; releasing out_ready drains A then B in order.
REQ-030 Assert flush together with in_valid=1 at occupancy 1 -> next cycle out_valid=0, occupancy=0, out_data=0 (ZERO_ON_BUBBLE=1), and the new entry is never output.
REQ-031 Send in_exc=1, in_exc_addr=0xDEADBEEF under random out_ready -> out_exc=1 and out_exc_addr=0xDEADBEEF presented alongside the matching out_data.
REQ-032 With CW=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cycles=15 and holds at 15; a flush leaves it at 15; asserting reset_n=0 clears it to 0 immediately.
